// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: drives an ack-based instruction memory and loads the
// IF/ID register, handling decode stalls (freeze) and taken-branch redirects.
module if_fetch_unit #(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter int           PC_STEP  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         freezeIn,
    input  logic         branchTakenIn,
    input  logic [N-1:0] branchAddrIn,
    output logic         imemReqOut,
    output logic [N-1:0] imemAddrOut,
    input  logic         imemAckIn,
    input  logic [N-1:0] imemDataIn,
    output logic [N-1:0] instructionOut,
    output logic [N-1:0] pcOut,
    output logic         validOut
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

    state_t       state_reg,  state_next;
    logic [N-1:0] pc_reg,     pc_next;
    logic [N-1:0] target_reg, target_next;
    logic [N-1:0] hold_reg,   hold_next;
    logic [N-1:0] instr_reg,  instr_next;
    logic [N-1:0] pcout_reg,  pcout_next;
    logic         valid_reg,  valid_next;

    logic [N-1:0] pc_inc;
    logic         load_new;
    logic [N-1:0] new_instr;

    // Wraps modulo 2^N by construction.
    assign pc_inc = pc_reg + N'(PC_STEP);

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        target_next = target_reg;
        hold_next   = hold_reg;
        load_new    = 1'b0;
        new_instr   = '0;

        case (state_reg)
            IDLE: begin
                state_next = FETCH;
            end
            FETCH: begin
                if (imemAckIn) begin
                    if (branchTakenIn) begin
                        pc_next = branchAddrIn;
                    end else if (freezeIn) begin
                        hold_next  = imemDataIn;
                        state_next = HOLD;
                    end else begin
                        load_new  = 1'b1;
                        new_instr = imemDataIn;
                        pc_next   = pc_inc;
                    end
                end else if (branchTakenIn) begin
                    // The outstanding request must complete at its old address.
                    target_next = branchAddrIn;
                    state_next  = DISCARD;
                end
            end
            HOLD: begin
                if (branchTakenIn) begin
                    pc_next    = branchAddrIn;
                    state_next = FETCH;
                end else if (!freezeIn) begin
                    load_new   = 1'b1;
                    new_instr  = hold_reg;
                    pc_next    = pc_inc;
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                if (branchTakenIn) begin
                    target_next = branchAddrIn;
                end
                if (imemAckIn) begin
                    pc_next    = branchTakenIn ? branchAddrIn : target_reg;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // IF/ID priority: flush on branch, then hold on freeze, then new word, else bubble.
    always_comb begin
        instr_next = '0;
        pcout_next = '0;
        valid_next = 1'b0;
        if (branchTakenIn) begin
            instr_next = '0;
            pcout_next = '0;
            valid_next = 1'b0;
        end else if (freezeIn) begin
            instr_next = instr_reg;
            pcout_next = pcout_reg;
            valid_next = valid_reg;
        end else if (load_new) begin
            instr_next = new_instr;
            pcout_next = pc_inc;
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            pc_reg     <= RESET_PC;
            target_reg <= '0;
            hold_reg   <= '0;
            instr_reg  <= '0;
            pcout_reg  <= '0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            target_reg <= target_next;
            hold_reg   <= hold_next;
            instr_reg  <= instr_next;
            pcout_reg  <= pcout_next;
            valid_reg  <= valid_next;
        end
    end

    assign imemReqOut     = (state_reg == FETCH) || (state_reg == DISCARD);
    assign imemAddrOut    = pc_reg;
    assign instructionOut = instr_reg;
    assign pcOut          = pcout_reg;
    assign validOut       = valid_reg;

endmodule
